// File: rtl/ndma_write_mgr.sv
// NanoDMA write manager: buffers address/data beats in a small FIFO and issues them as OBI writes, one outstanding.
// Optional completed-write counter on wr_count_o is built when NDMA_WR_STATS_EN is defined.
module ndma_write_mgr #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wvalid_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic                     wready_o,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     done_o,
  output logic                     write_mgr_req_o,
  input  logic                     write_mgr_gnt_i,
  output logic [AW-1:0]            write_mgr_addr_o,
  output logic                     write_mgr_we_o,
  output logic [DW/8-1:0]          write_mgr_be_o,
  output logic [DW-1:0]            write_mgr_wdata_o,
  input  logic                     write_mgr_rvalid_i,
  output logic [15:0]              wr_count_o,
  output logic [1:0]               state_o
);

  // Handshakes: a beat moves on wvalid_i && wready_o; an OBI request is
  // accepted on req && gnt and req stays high with stable addr/wdata until then;
  // the response completes on rvalid while in RESP.

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q;
  logic          clear_pend_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          full, empty;
  logic          push, pop, flush;
  logic          fifo_avail;
  logic          load_head;
  logic          req;
  logic          done;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A clear seen in REQ is held back until gnt so the request is never withdrawn.
  assign flush = (clear_i && (state_q != REQ)) ||
                 ((state_q == REQ) && write_mgr_gnt_i && (clear_i || clear_pend_q));

  assign push       = wvalid_i && !full && !flush;
  assign fifo_avail = flush ? 1'b0 : (!empty || push);

  // Entering REQ from RESP with an empty FIFO means the head is the beat arriving now.
  assign head_addr = empty ? waddr_i : addr_mem[rd_ptr_q[PW-1:0]];
  assign head_data = empty ? wdata_i : data_mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) state_d = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (write_mgr_gnt_i) begin
          pop     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (write_mgr_rvalid_i) begin
          done    = 1'b1;
          state_d = fifo_avail ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_head = (state_d == REQ) && (state_q != REQ);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      clear_pend_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;

      if (push) wr_ptr_q <= wr_ptr_q + ONE;

      if (flush)    rd_ptr_q <= wr_ptr_q;
      else if (pop) rd_ptr_q <= rd_ptr_q + ONE;

      if (flush) begin
        level_q <= '0;
      end else begin
        case ({push, pop})
          2'b10:   level_q <= level_q + ONE;
          2'b01:   level_q <= level_q - ONE;
          default: level_q <= level_q;
        endcase
      end

      if ((state_q == REQ) && write_mgr_gnt_i)   clear_pend_q <= 1'b0;
      else if ((state_q == REQ) && clear_i)      clear_pend_q <= 1'b1;

      // addr_q/wdata_q also serve as the issued-beat register through RESP.
      if (load_head) begin
        addr_q  <= head_addr;
        wdata_q <= head_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q[PW-1:0]] <= waddr_i;
      data_mem[wr_ptr_q[PW-1:0]] <= wdata_i;
    end
  end

`ifdef NDMA_WR_STATS_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_count_q <= '0;
    end else if (done && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  assign wr_count_o = wr_count_q;
`else
  assign wr_count_o = '0;
`endif

  assign wready_o          = !full;
  assign busy_o            = !empty || (state_q != IDLE);
  assign level_o           = level_q;
  assign done_o            = done;
  assign write_mgr_req_o   = req;
  assign write_mgr_addr_o  = addr_q;
  assign write_mgr_wdata_o = wdata_q;
  assign write_mgr_we_o    = 1'b1;
  assign write_mgr_be_o    = {(DW/8){1'b1}};
  assign state_o           = state_q;

endmodule
